// File: rtl/cp0_ctrl.sv
// Coprocessor-0 responder: SR/Cause/EPC/PRId storage, mfc0/mtc0/eret service,
// and a single-cycle handler request combining level interrupts with M-stage exceptions.
module cp0_ctrl #(
   parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
   parameter logic [31:0] PRID      = 32'h2022_0007
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hw_int,
   input  logic [4:0]  sel,
   input  logic [31:0] wdata,
   input  logic        we,
   input  logic [31:0] pc_m,
   input  logic        bd_m,
   input  logic [4:0]  exc_m,
   input  logic        eret_m,
   output logic [31:0] rdata,
   output logic        req,
   output logic [31:0] handler_pc,
   output logic [31:0] epc_out
);

   localparam logic [4:0] SEL_SR    = 5'd12;
   localparam logic [4:0] SEL_CAUSE = 5'd13;
   localparam logic [4:0] SEL_EPC   = 5'd14;
   localparam logic [4:0] SEL_PRID  = 5'd15;

   logic [5:0]  im_q, im_d;
   logic        exl_q, exl_d;
   logic        ie_q, ie_d;
   logic        bd_q, bd_d;
   logic [5:0]  ip_q, ip_d;
   logic [4:0]  exc_code_q, exc_code_d;
   logic [31:2] epc_q, epc_d;

   logic int_req;
   logic exc_req;
   logic unused_pc_lsb;

   // Interrupts look at the live lines so a request is raised in the same cycle it appears.
   assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
   assign exc_req = (exc_m != 5'd0) & ~exl_q;
   assign req     = int_req | exc_req;

   assign handler_pc    = EXC_ENTRY;
   assign epc_out       = {epc_q, 2'b00};
   assign unused_pc_lsb = ^pc_m[1:0];

   always_comb begin
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ip_d       = hw_int;
      exc_code_d = exc_code_q;
      epc_d      = epc_q;
      // A taken request flushes the M-stage instruction, so its eret or mtc0 is dropped.
      if (req) begin
         exl_d      = 1'b1;
         exc_code_d = int_req ? 5'd0 : exc_m;
         bd_d       = bd_m;
         epc_d      = bd_m ? (pc_m[31:2] - 30'd1) : pc_m[31:2];
      end else if (eret_m) begin
         exl_d = 1'b0;
      end else if (we) begin
         case (sel)
            SEL_SR: begin
               im_d  = wdata[15:10];
               exl_d = wdata[1];
               ie_d  = wdata[0];
            end
            SEL_EPC: epc_d = wdata[31:2];
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q       <= 6'd0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= 6'd0;
         exc_code_q <= 5'd0;
         epc_q      <= 30'd0;
      end else begin
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ip_q       <= ip_d;
         exc_code_q <= exc_code_d;
         epc_q      <= epc_d;
      end
   end

   always_comb begin
      rdata = 32'd0;
      case (sel)
         SEL_SR:    rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
         SEL_CAUSE: rdata = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
         SEL_EPC:   rdata = {epc_q, 2'b00};
         SEL_PRID:  rdata = PRID;
         default:   rdata = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_cp0_ctrl.sv
// Scenario bench for cp0_ctrl: expected values are queued as stimulus is applied
// and popped when the corresponding DUT output is sampled.
module tb_cp0_ctrl;

   localparam logic [31:0] EXC_ENTRY = 32'h0000_4180;
   localparam logic [31:0] PRID      = 32'h2022_0007;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  hw_int = '0;
   logic [4:0]  sel = '0;
   logic [31:0] wdata = '0;
   logic        we = 1'b0;
   logic [31:0] pc_m = '0;
   logic        bd_m = 1'b0;
   logic [4:0]  exc_m = '0;
   logic        eret_m = 1'b0;
   logic [31:0] rdata;
   logic        req;
   logic [31:0] handler_pc;
   logic [31:0] epc_out;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];
   logic [31:0] obs, exp;

   cp0_ctrl dut (
      .clk(clk), .reset(reset), .hw_int(hw_int), .sel(sel), .wdata(wdata), .we(we),
      .pc_m(pc_m), .bd_m(bd_m), .exc_m(exc_m), .eret_m(eret_m), .rdata(rdata),
      .req(req), .handler_pc(handler_pc), .epc_out(epc_out)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog timeout reached got running want finished");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [4:0] s, output logic [31:0] v);
      sel = s;
      #1;
      v = rdata;
   endtask

   task automatic test_reset();
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      exp_q.push_back(32'd0); exp_q.push_back(PRID); exp_q.push_back(32'd0);
      exp_q.push_back(EXC_ENTRY); exp_q.push_back(32'd0);
      #3;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_req got %h want %h", obs, exp); end
      rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_sr got %h want %h", obs, exp); end
      rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_cause got %h want %h", obs, exp); end
      rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_epc got %h want %h", obs, exp); end
      rd(5'd15, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_prid got %h want %h", obs, exp); end
      obs = epc_out; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reset_epc_out got %h want %h", obs, exp); end
      obs = handler_pc; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL handler_pc got %h want %h", obs, exp); end
      rd(5'd3, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL unmapped_read got %h want %h", obs, exp); end
      tick();
      reset = 1'b1;
      tick();
      exp_q.push_back(32'd0);
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL req_after_release got %h want %h", obs, exp); end
   endtask

   task automatic test_interrupt();
      sel = 5'd12; wdata = 32'h0000_1001; we = 1'b1;
      tick();
      we = 1'b0; pc_m = 32'h0000_3018; bd_m = 1'b0; hw_int = 6'b000100;
      exp_q.push_back(32'd1);
      #1;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL int_req got %h want %h", obs, exp); end
      tick();
      exp_q.push_back(32'h0000_3018); exp_q.push_back(32'h0000_1000);
      exp_q.push_back(32'h0000_1003); exp_q.push_back(32'h0000_3018);
      rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL int_epc got %h want %h", obs, exp); end
      rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL int_cause got %h want %h", obs, exp); end
      rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL int_sr got %h want %h", obs, exp); end
      obs = epc_out; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL int_epc_out got %h want %h", obs, exp); end
      for (int i = 0; i < 5; i++) begin
         exp_q.push_back(32'd0);
         obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
         if (obs !== exp) begin errors++; $display("FAIL int_req_masked cycle %0d got %h want %h", i, obs, exp); end
         tick();
      end
      hw_int = 6'd0; eret_m = 1'b1;
      tick();
      eret_m = 1'b0;
      exp_q.push_back(32'h0000_1001);
      rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL eret_sr got %h want %h", obs, exp); end
   endtask

   task automatic test_exc_delay_slot();
      exc_m = 5'd12; pc_m = 32'h0000_3040; bd_m = 1'b1;
      exp_q.push_back(32'd1);
      #1;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL exc_req got %h want %h", obs, exp); end
      tick();
      exc_m = 5'd0; bd_m = 1'b0;
      exp_q.push_back(32'h0000_303C); exp_q.push_back(32'h8000_0030); exp_q.push_back(32'd0);
      rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL bd_epc got %h want %h", obs, exp); end
      rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL bd_cause got %h want %h", obs, exp); end
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL exc_req_one_cycle got %h want %h", obs, exp); end
      eret_m = 1'b1;
      tick();
      eret_m = 1'b0;
   endtask

   task automatic test_priority();
      hw_int = 6'b000100; exc_m = 5'd4; we = 1'b1; sel = 5'd14;
      wdata = 32'h1234_5678; pc_m = 32'h0000_3100; bd_m = 1'b0;
      exp_q.push_back(32'd1);
      #1;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL prio_req got %h want %h", obs, exp); end
      tick();
      hw_int = 6'd0; exc_m = 5'd0; we = 1'b0;
      exp_q.push_back(32'h0000_1000); exp_q.push_back(32'h0000_3100);
      rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL prio_cause got %h want %h", obs, exp); end
      rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL prio_mtc0_dropped got %h want %h", obs, exp); end
      eret_m = 1'b1;
      tick();
      eret_m = 1'b0;
   endtask

   task automatic test_mtc0();
      sel = 5'd14; wdata = 32'h1234_5677; we = 1'b1; tick();
      sel = 5'd13; wdata = 32'hFFFF_FFFF; tick();
      sel = 5'd15; wdata = 32'h0000_0000; tick();
      sel = 5'd12; wdata = 32'hFFFF_FFFC; tick();
      we = 1'b0;
      exp_q.push_back(32'h1234_5674); exp_q.push_back(32'h0000_0000);
      exp_q.push_back(PRID); exp_q.push_back(32'h0000_FC00);
      rd(5'd14, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL mtc0_epc got %h want %h", obs, exp); end
      rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL mtc0_cause_ro got %h want %h", obs, exp); end
      rd(5'd15, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL mtc0_prid_ro got %h want %h", obs, exp); end
      rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL mtc0_sr got %h want %h", obs, exp); end
   endtask

   task automatic test_mask_eret();
      hw_int = 6'b000001; pc_m = 32'h0000_3200;
      sel = 5'd12; wdata = 32'h0000_0401; we = 1'b1;
      exp_q.push_back(32'd0);
      #1;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL ie_off_req got %h want %h", obs, exp); end
      tick();
      we = 1'b0;
      exp_q.push_back(32'd1);
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL ie_enable_req got %h want %h", obs, exp); end
      tick();
      exc_m = 5'd10;
      exp_q.push_back(32'd0);
      #1;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL nested_exc_req got %h want %h", obs, exp); end
      tick();
      exc_m = 5'd0;
      exp_q.push_back(32'h0000_0400);
      rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL nested_cause got %h want %h", obs, exp); end
      eret_m = 1'b1;
      exp_q.push_back(32'd0);
      #1;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL eret_cycle_req got %h want %h", obs, exp); end
      tick();
      eret_m = 1'b0;
      exp_q.push_back(32'd1); exp_q.push_back(32'h0000_0401);
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL post_eret_req got %h want %h", obs, exp); end
      rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL post_eret_sr got %h want %h", obs, exp); end
      tick();
      exp_q.push_back(32'h0000_0403);
      rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL reentry_sr got %h want %h", obs, exp); end
   endtask

   task automatic test_async_reset();
      #3;
      reset = 1'b0;
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      rd(5'd12, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL async_sr got %h want %h", obs, exp); end
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL async_req got %h want %h", obs, exp); end
      obs = epc_out; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL async_epc_out got %h want %h", obs, exp); end
      rd(5'd13, obs); exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL async_cause got %h want %h", obs, exp); end
      tick();
      reset = 1'b1;
      exp_q.push_back(32'd0);
      #1;
      obs = {31'd0, req}; exp = exp_q.pop_front(); checks++;
      if (obs !== exp) begin errors++; $display("FAIL release_req got %h want %h", obs, exp); end
      tick();
      hw_int = 6'd0;
   endtask

   initial begin
      test_reset();
      test_interrupt();
      test_exc_delay_slot();
      test_priority();
      test_mtc0();
      test_mask_eret();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
